// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding unit: forward-select encoding,
// per-stage destination/source shadow record and small match helpers.
package hazard_pkg;

  localparam int HZ_REG_W = 5;

  typedef enum logic [1:0] {
    FWD_REG  = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10,
    FWD_ZERO = 2'b11
  } fwd_sel_t;

  typedef struct packed {
    logic                valid;
    logic [HZ_REG_W-1:0] rs1;
    logic [HZ_REG_W-1:0] rs2;
    logic                use1;
    logic                use2;
    logic [HZ_REG_W-1:0] rd;
    logic                regwrite;
    logic                memread;
  } stage_info_t;

  localparam int STAGE_W = $bits(stage_info_t);
  localparam stage_info_t STAGE_BUBBLE = stage_info_t'({STAGE_W{1'b0}});

  // True when a writer stage produces the register an EX operand needs (x0 never matches).
  function automatic logic writes_src(input logic rw, input logic [HZ_REG_W-1:0] rd,
                                      input logic [HZ_REG_W-1:0] rs, input logic use_rs);
    return rw && (rd != {HZ_REG_W{1'b0}}) && (rd == rs) && use_rs;
  endfunction

  // Youngest producer wins; a load sitting in MEM has no data yet and never forwards.
  function automatic fwd_sel_t pick_fwd(input logic mem_rw, input logic mem_mr,
                                        input logic [HZ_REG_W-1:0] mem_rd,
                                        input logic wb_rw, input logic [HZ_REG_W-1:0] wb_rd,
                                        input logic [HZ_REG_W-1:0] rs, input logic use_rs);
    fwd_sel_t sel;
    if (!mem_mr && writes_src(mem_rw, mem_rd, rs, use_rs)) begin
      sel = FWD_MEM;
    end else if (writes_src(wb_rw, wb_rd, rs, use_rs)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_REG;
    end
    return sel;
  endfunction

endpackage

// File: rtl/haz_shadow_stage.sv
// One pipeline shadow register holding a stage_info_t record, with
// synchronous reset, freeze and bubble insertion.
module haz_shadow_stage
  import hazard_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  input  logic               bubble,
  input  logic [STAGE_W-1:0] stage_in,
  output logic [STAGE_W-1:0] stage_out
);

  logic [STAGE_W-1:0] stage_d;
  logic [STAGE_W-1:0] stage_q;

  always_comb begin
    stage_d = stage_q;
    if (hold) begin
      stage_d = stage_q;
    end else if (bubble) begin
      stage_d = STAGE_BUBBLE;
    end else begin
      stage_d = stage_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= STAGE_BUBBLE;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign stage_out = stage_q;

endmodule

// File: rtl/hazard_fwd_unit.sv
// Load-use stall detection and EX operand forward selects, driven from a
// private EX/MEM/WB shadow of instruction register usage.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_W = HZ_REG_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  output logic             stall,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  stage_info_t        id_info;
  stage_info_t        ex_info;
  stage_info_t        mem_info;
  stage_info_t        wb_info;
  logic [STAGE_W-1:0] ex_vec;
  logic [STAGE_W-1:0] mem_vec;
  logic [STAGE_W-1:0] wb_vec;
  logic               ex_bubble;
  logic               load_hit;
  logic [CNT_W-1:0]   cnt_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               unused_fields;

  always_comb begin
    id_info          = STAGE_BUBBLE;
    id_info.valid    = id_valid;
    id_info.rs1      = id_rs1;
    id_info.rs2      = id_rs2;
    id_info.use1     = id_use_rs1;
    id_info.use2     = id_use_rs2;
    id_info.rd       = id_rd;
    id_info.regwrite = id_regwrite;
    id_info.memread  = id_memread;
  end

  assign ex_bubble = flush | stall | ~id_valid;

  haz_shadow_stage u_ex (
    .clk(clk), .rst(rst), .hold(hold), .bubble(ex_bubble),
    .stage_in(id_info), .stage_out(ex_vec)
  );

  haz_shadow_stage u_mem (
    .clk(clk), .rst(rst), .hold(hold), .bubble(1'b0),
    .stage_in(ex_vec), .stage_out(mem_vec)
  );

  haz_shadow_stage u_wb (
    .clk(clk), .rst(rst), .hold(hold), .bubble(1'b0),
    .stage_in(mem_vec), .stage_out(wb_vec)
  );

  assign ex_info  = stage_info_t'(ex_vec);
  assign mem_info = stage_info_t'(mem_vec);
  assign wb_info  = stage_info_t'(wb_vec);

  // A load in EX whose result the ID instruction needs costs exactly one bubble.
  always_comb begin
    load_hit = ex_info.valid && ex_info.memread && (ex_info.rd != {HZ_REG_W{1'b0}}) &&
               ((id_use_rs1 && (id_rs1 == ex_info.rd)) ||
                (id_use_rs2 && (id_rs2 == ex_info.rd)));
    stall    = id_valid && !flush && load_hit;
  end

  always_comb begin
    fwd_a_sel = pick_fwd(mem_info.regwrite, mem_info.memread, mem_info.rd,
                         wb_info.regwrite, wb_info.rd, ex_info.rs1, ex_info.use1);
    fwd_b_sel = pick_fwd(mem_info.regwrite, mem_info.memread, mem_info.rd,
                         wb_info.regwrite, wb_info.rd, ex_info.rs2, ex_info.use2);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!hold && stall && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_count = cnt_q;

  assign unused_fields = ^{ex_info.regwrite,
                           mem_info.valid, mem_info.rs1, mem_info.rs2, mem_info.use1, mem_info.use2,
                           wb_info.valid, wb_info.rs1, wb_info.rs2, wb_info.use1, wb_info.use2,
                           wb_info.memread};

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench for hazard_fwd_unit: a reference pipeline model pushes
// expected outputs each cycle, popped and compared at the falling edge.
module tb_hazard_fwd_unit;

  logic        clk = 1'b0;
  logic        rst, hold, flush, id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2, id_regwrite, id_memread;
  logic        stall, stall2;
  logic [1:0]  fwd_a_sel, fwd_b_sel, fa2, fb2;
  logic [15:0] stall_count;
  logic [1:0]  cnt2;

  always #5 clk = ~clk;

  hazard_fwd_unit #(.REG_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .stall(stall), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_count(stall_count)
  );

  hazard_fwd_unit #(.REG_W(5), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .stall(stall2), .fwd_a_sel(fa2), .fwd_b_sel(fb2), .stall_count(cnt2)
  );

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } ins_t;

  typedef struct packed {
    logic        st;
    logic [1:0]  a;
    logic [1:0]  b;
    logic [15:0] c;
    logic [1:0]  c2;
  } exp_t;

  ins_t  m_ex, m_mem, m_wb;
  int    m_cnt, m_cnt2;
  logic  m_last_st;
  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  logic       last_st;
  logic [1:0] last_a, last_b;
  int         ns;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [4:0] rs, input logic u);
    if (!u || rs == 5'd0) return 2'b00;
    if (m_mem.rw && !m_mem.mr && m_mem.rd == rs) return 2'b10;
    if (m_wb.rw && m_wb.rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  // One clock: drive, predict, compare at negedge, advance model at posedge.
  task automatic cyc(input logic r, input logic h, input logic f, input logic v,
                     input logic [4:0] i_rs1, input logic [4:0] i_rs2, input logic [4:0] i_rd,
                     input logic i_u1, input logic i_u2, input logic i_rw, input logic i_mr,
                     input string tag);
    exp_t e;
    exp_t got;
    ins_t nid;
    logic mst;
    rst = r; hold = h; flush = f; id_valid = v;
    id_rs1 = i_rs1; id_rs2 = i_rs2; id_rd = i_rd;
    id_use_rs1 = i_u1; id_use_rs2 = i_u2; id_regwrite = i_rw; id_memread = i_mr;
    mst = v && !f && m_ex.v && m_ex.mr && m_ex.rd != 5'd0 &&
          ((i_u1 && i_rs1 == m_ex.rd) || (i_u2 && i_rs2 == m_ex.rd));
    e.st = mst;
    e.a  = m_fwd(m_ex.rs1, m_ex.u1);
    e.b  = m_fwd(m_ex.rs2, m_ex.u2);
    e.c  = m_cnt[15:0];
    e.c2 = m_cnt2[1:0];
    exp_q.push_back(e);
    m_last_st = mst;
    @(negedge clk);
    got = exp_q.pop_front();
    last_st = stall; last_a = fwd_a_sel; last_b = fwd_b_sel;
    check_val({tag, ".stall"}, 32'(stall), 32'(got.st));
    check_val({tag, ".fwd_a"}, 32'(fwd_a_sel), 32'(got.a));
    check_val({tag, ".fwd_b"}, 32'(fwd_b_sel), 32'(got.b));
    check_val({tag, ".count"}, 32'(stall_count), 32'(got.c));
    check_val({tag, ".count2"}, 32'(cnt2), 32'(got.c2));
    nid = '{v: 1'b1, rs1: i_rs1, rs2: i_rs2, u1: i_u1, u2: i_u2, rd: i_rd, rw: i_rw, mr: i_mr};
    if (r) begin
      m_ex = '0; m_mem = '0; m_wb = '0; m_cnt = 0; m_cnt2 = 0;
    end else if (!h) begin
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = (f || mst || !v) ? ins_t'(0) : nid;
      if (mst) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic bub(input string tag);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  // Present an instruction in ID, re-presenting it while the model says it stalls.
  task automatic issue(input string tag, input logic [4:0] i_rd, input logic [4:0] i_rs1,
                       input logic [4:0] i_rs2, input logic i_u1, input logic i_u2,
                       input logic i_rw, input logic i_mr, output int n_stall);
    n_stall = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, i_rs1, i_rs2, i_rd, i_u1, i_u2, i_rw, i_mr, tag);
      if (m_last_st) n_stall++;
      else break;
    end
    if (n_stall >= 4) check_val({tag, ".stall_bound"}, 32'(n_stall), 32'd1);
  endtask

  initial begin
    m_ex = '0; m_mem = '0; m_wb = '0; m_cnt = 0; m_cnt2 = 0;
    rst = 1'b1; hold = 1'b0; flush = 1'b0; id_valid = 1'b0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_regwrite = 1'b0; id_memread = 1'b0;
    @(posedge clk); #1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
    check_val("reset.direct_count", 32'(stall_count), 32'd0);
    bub("idle");

    // ALU chain on x5
    issue("alu.w5", 5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, ns);
    issue("alu.r1", 5'd6, 5'd5, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, ns);
    issue("alu.r2", 5'd9, 5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, ns);
    check_val("alu.mem_fwd_a", 32'(last_a), 32'd2);
    issue("alu.nop", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ns);
    check_val("alu.wb_fwd_b", 32'(last_b), 32'd1);
    repeat (3) bub("alu.drain");

    // Double writer of x7
    issue("dbl.w1", 5'd7, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, ns);
    issue("dbl.w2", 5'd7, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, ns);
    issue("dbl.rd", 5'd8, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, ns);
    issue("dbl.nop", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ns);
    check_val("dbl.youngest", 32'(last_a), 32'd2);
    repeat (3) bub("dbl.drain");

    // Load-use on x3
    issue("lu.lw", 5'd3, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, ns);
    issue("lu.add", 5'd10, 5'd3, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, ns);
    check_val("lu.stall_cycles", 32'(ns), 32'd1);
    check_val("lu.count", 32'(stall_count), 32'd1);
    issue("lu.nop", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ns);
    check_val("lu.wb_fwd_a", 32'(last_a), 32'd1);
    repeat (3) bub("lu.drain");

    // x0 never forwards; flush beats stall
    issue("x0.w", 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, ns);
    issue("x0.r", 5'd11, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, ns);
    issue("x0.nop", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ns);
    check_val("x0.sel_a", 32'(last_a), 32'd0);
    issue("fl.lw", 5'd4, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, ns);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 5'd0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0, "fl.add");
    check_val("fl.no_stall", 32'(last_st), 32'd0);
    check_val("fl.count", 32'(stall_count), 32'd1);
    repeat (3) bub("fl.drain");

    // Hold during a load-use
    issue("hd.lw", 5'd8, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, ns);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 5'd8, 5'd0, 5'd13, 1'b1, 1'b0, 1'b1, 1'b0, "hd.frozen");
      check_val("hd.stall_seen", 32'(last_st), 32'd1);
    end
    check_val("hd.count_frozen", 32'(stall_count), 32'd1);
    issue("hd.add", 5'd13, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, ns);
    check_val("hd.count", 32'(stall_count), 32'd2);

    // Saturation of the 2-bit counter
    for (int k = 0; k < 5; k++) begin
      issue("sat.lw", 5'd14, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, ns);
      issue("sat.add", 5'd15, 5'd0, 5'd14, 1'b0, 1'b1, 1'b1, 1'b0, ns);
    end
    check_val("sat.count16", 32'(stall_count), 32'd7);
    check_val("sat.count2", 32'(cnt2), 32'd3);

    // Reset in the middle of a load-use
    issue("mr.lw", 5'd9, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, ns);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 5'd0, 5'd16, 1'b1, 1'b0, 1'b1, 1'b0, "mr.rst");
    check_val("mr.count", 32'(stall_count), 32'd0);
    issue("mr.add", 5'd16, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, ns);
    check_val("mr.no_stall", 32'(ns), 32'd0);

    // Random traffic on a small register set
    for (int k = 0; k < 300; k++) begin
      cyc(1'b0, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
          1'($urandom_range(0, 3) != 0),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
